mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Multiply/divide sequencer that owns the HI/LO register pair of the E-stage multiply/divide resource.
- Accepts one mult/div request at a time, holds busy for a fixed latency, then commits the result to HI/LO.
- Services mthi/mtlo writes and mfhi/mflo reads.
- Its start and busy outputs feed the global stall unit; its read result goes into the M-stage pipeline register alongside the ALU result.

Parameters:
WIDTH, 32, operand/HI/LO width
MUL_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  qualifies a mult/div request in op this cycle
op  in  4  MDU operation code (see package)
a  in  WIDTH  rs operand, forwarded
b  in  WIDTH  rt operand, forwarded
busy  out  1  registered; high while a mult/div is in flight
done  out  1  registered one-cycle pulse on the cycle after HI/LO commit
c  out  WIDTH  combinational read: HI for MFHI, LO for MFLO, else 0
hi  out  WIDTH  current HI register
lo  out  WIDTH  current LO register

Behaviour:
- Reset, reset=0 asynchronously: state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0. Takes effect mid-operation; the in-flight result is discarded and no done pulse is produced.
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9-15 are treated as NONE.
- States: IDLE, MUL, DIV.
  - IDLE & start & op∈{MULT,MULTU}: latch a, b, op; cnt=MUL_CYCLES-1; go to MUL; busy=1 from the next cycle.
  - IDLE & start & op∈{DIV,DIVU}: same, with cnt=DIV_CYCLES-1; go to DIV.
  - MUL/DIV with cnt!=0: cnt decrements.
  - MUL/DIV with cnt==0: commit HI/LO on this edge, busy=0, done=1 for the next cycle, go to IDLE.
- busy is high for exactly MUL_CYCLES or DIV_CYCLES cycles. The new HI/LO are visible on c the cycle busy falls.
- start with any other op, or start while busy, is ignored. The stall unit guarantees the latter never happens; the block must not corrupt state if it does.
- Arithmetic uses the latched operands only. Inputs changing during busy have no effect.
  - MULT: signed 64-bit product; HI=upper, LO=lower.
  - MULTU: unsigned 64-bit product; HI=upper, LO=lower.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend. 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
  - Divisor 0 (DIV/DIVU): full DIV_CYCLES busy, done pulses, HI/LO unchanged.
- MTHI/MTLO: write a into HI/LO on the edge when busy=0 and state=IDLE; start is don't-care. While busy they are ignored.
- Simultaneous MTHI and commit in the same cycle cannot occur, because commit only happens with busy=1.
- c is purely combinational from op, hi, lo. During busy, c shows the old HI/LO; the stall unit prevents consuming it.

Decomposition:
- Shared package mdu_pkg:
  - op code localparams (MDU_NONE..MDU_MTLO)
  - state encoding (S_IDLE, S_MUL, S_DIV)
  - default latency constants
- The stall/decoder modules reference the same op codes.
- One combinational sub-module, mdu_arith: takes the latched op, a, b and produces the 64-bit {hi,lo} result including the div-by-zero and overflow rules.
- mdu_seq keeps the FSM, counter, latches, HI/LO and read mux.

Test Plan:
1. Reset, then start MULT a=0xFFFFFFFF b=0x00000002 -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; done pulses once on the cycle after commit.
2. start MULTU a=0xFFFFFFFF b=0x00000002 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE; op=MFHI gives c=0x00000001.
3. start DIV a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. MTHI a=0x12345678, MTLO a=0x9ABCDEF0 while idle, then DIVU b=0 -> busy 10 cycles, done pulses, HI=0x12345678 and LO=0x9ABCDEF0 unchanged.
5. start MULT, then in busy cycle 2 drive MTHI a=0xDEADBEEF plus start DIV with new operands -> both ignored; final HI/LO equal the original MULT result; busy total is 5.
6. start DIV, pull reset low in busy cycle 3 (between edges) -> busy, hi, lo go to 0 immediately; no done pulse after release; a new MULT after release completes normally in 5 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared op codes, state encoding and default latencies for the
//               E-stage multiply/divide sequencer and its users.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    // MDU operation codes; 9..15 behave as MDU_NONE
    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } mdu_state_t;

    // Default widths and latencies
    localparam int DEF_WIDTH      = 32;
    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;

endpackage

`default_nettype wire

// File: rtl/mdu_seq_if.sv
// ============================================================================
// Module      : mdu_seq_if
// Description : Request/response bundle between the pipeline and the
//               multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues requests, observes status and read data
    modport master (
        output start, op, a, b,
        input  busy, done, c, hi, lo
    );

    // Sequencer side
    modport slave (
        input  start, op, a, b,
        output busy, done, c, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// Module      : mdu_arith
// Description : Combinational multiply/divide datapath producing {hi,lo};
//               divide-by-zero keeps the current HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic [3:0]         op,
    input  wire logic [WIDTH-1:0]   a,
    input  wire logic [WIDTH-1:0]   b,
    input  wire logic [WIDTH-1:0]   hi_in,
    input  wire logic [WIDTH-1:0]   lo_in,
    output logic      [2*WIDTH-1:0] result
);

    logic signed [2*WIDTH-1:0] a_sx;
    logic signed [2*WIDTH-1:0] b_sx;
    logic        [2*WIDTH-1:0] prod_s;
    logic        [2*WIDTH-1:0] prod_u;
    logic        [WIDTH-1:0]   a_mag;
    logic        [WIDTH-1:0]   b_mag;
    logic        [WIDTH-1:0]   q_mag;
    logic        [WIDTH-1:0]   r_mag;
    logic        [WIDTH-1:0]   quo_s;
    logic        [WIDTH-1:0]   rem_s;
    logic        [WIDTH-1:0]   quo_u;
    logic        [WIDTH-1:0]   rem_u;
    logic                      b_zero;

    assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign b_zero = (b == '0);

    // Signed divide on magnitudes: the most-negative dividend over -1 wraps
    // back to itself naturally, and the remainder follows the dividend sign.
    assign a_mag  = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag  = b[WIDTH-1] ? (~b + 1'b1) : b;
    assign q_mag  = b_zero ? '0 : (a_mag / b_mag);
    assign r_mag  = b_zero ? '0 : (a_mag % b_mag);
    assign quo_s  = (a[WIDTH-1] ^ b[WIDTH-1]) ? (~q_mag + 1'b1) : q_mag;
    assign rem_s  = a[WIDTH-1] ? (~r_mag + 1'b1) : r_mag;
    assign quo_u  = b_zero ? '0 : (a / b);
    assign rem_u  = b_zero ? '0 : (a % b);

    // Select the result for the latched op; anything else keeps HI/LO
    always_comb begin
        result = {hi_in, lo_in};
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV:   if (!b_zero) result = {rem_s, quo_s};
            MDU_DIVU:  if (!b_zero) result = {rem_u, quo_u};
            default:   result = {hi_in, lo_in};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// ============================================================================
// Module      : mdu_seq
// Description : Multiply/divide sequencer owning HI/LO: fixed-latency busy
//               window, commit to HI/LO, mthi/mtlo writes and mfhi/mflo read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  wire logic clk,
    input  wire logic reset,
    mdu_seq_if.slave  bus
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [3:0]         op_q,    op_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic [WIDTH-1:0]   hi_q,    hi_d;
    logic [WIDTH-1:0]   lo_q,    lo_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [2*WIDTH-1:0] arith_res;

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_in  (hi_q),
        .lo_in  (lo_q),
        .result (arith_res)
    );

    // Next-state: accept requests in IDLE, count down, commit on terminal count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.op == MDU_MULT || bus.op == MDU_MULTU)) begin
                    state_d = S_MUL;
                    cnt_d   = MUL_LOAD;
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                end else if (bus.start && (bus.op == MDU_DIV || bus.op == MDU_DIVU)) begin
                    state_d = S_DIV;
                    cnt_d   = DIV_LOAD;
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                end else if (bus.op == MDU_MTHI) begin
                    hi_d = bus.a;
                end else if (bus.op == MDU_MTLO) begin
                    lo_d = bus.a;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    {hi_d, lo_d} = arith_res;
                    state_d      = S_IDLE;
                    done_d       = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, operand latches, HI/LO and registered status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MDU_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Read mux follows the live op, so it shows the old HI/LO while busy
    always_comb begin
        bus.c = '0;
        if (bus.op == MDU_MFHI)      bus.c = hi_q;
        else if (bus.op == MDU_MFLO) bus.c = lo_q;
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// ============================================================================
// Module      : tb_mdu_seq
// Description : Self-checking bench for mdu_seq: vector table of mult/div
//               operations plus directed mthi/mtlo, busy-overlap and
//               mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_seq;
    import mdu_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    mdu_seq_if #(.WIDTH(32)) bus ();

    mdu_seq #(
        .WIDTH      (32),
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Count busy cycles from just after the accepting edge; optionally
    // inject an mthi in busy cycle 2 and a new div request in cycle 3.
    task automatic count_busy(input bit inject, output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            if (inject && n == 2) begin
                bus.start = 1'b0;
                bus.op    = MDU_MTHI;
                bus.a     = 32'hDEADBEEF;
            end else if (inject && n == 3) begin
                bus.start = 1'b1;
                bus.op    = MDU_DIV;
                bus.a     = 32'd100;
                bus.b     = 32'd3;
            end else begin
                bus.start = 1'b0;
                bus.op    = MDU_NONE;
            end
            step();
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int cyc);
        int n;
        chk({name, "_idle_before"}, {63'd0, bus.busy}, 64'd0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        step();
        bus.start = 1'b0;
        bus.op    = MDU_NONE;
        bus.a     = 32'h5A5A5A5A;
        bus.b     = 32'hA5A5A5A5;
        count_busy(1'b0, n);
        chk({name, "_busy_cycles"}, 64'(n), 64'(cyc));
        chk({name, "_done"}, {63'd0, bus.done}, 64'd1);
        chk({name, "_hi"}, {32'd0, bus.hi}, {32'd0, exp_hi});
        chk({name, "_lo"}, {32'd0, bus.lo}, {32'd0, exp_lo});
        bus.op = MDU_MFHI;
        #1;
        chk({name, "_c_mfhi"}, {32'd0, bus.c}, {32'd0, exp_hi});
        bus.op = MDU_MFLO;
        #1;
        chk({name, "_c_mflo"}, {32'd0, bus.c}, {32'd0, exp_lo});
        bus.op = MDU_NONE;
        step();
        chk({name, "_done_single"}, {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        int  n;
        bit  saw_done;
        tests  = 0;
        failed = 0;

        vecs[0] = '{MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1] = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[4] = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[5] = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[6] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};

        bus.start = 1'b0;
        bus.op    = MDU_NONE;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b0;
        #23;
        chk("reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("reset_done", {63'd0, bus.done}, 64'd0);
        chk("reset_hi",   {32'd0, bus.hi},   64'd0);
        chk("reset_lo",   {32'd0, bus.lo},   64'd0);
        chk("reset_c_none", {32'd0, bus.c},  64'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].cyc);
        end

        // mthi/mtlo while idle, then divide by zero leaves them untouched
        bus.op = MDU_MTHI;
        bus.a  = 32'h12345678;
        step();
        bus.op = MDU_MTLO;
        bus.a  = 32'h9ABCDEF0;
        step();
        bus.op = MDU_NONE;
        chk("mthi_hi", {32'd0, bus.hi}, {32'd0, 32'h12345678});
        chk("mtlo_lo", {32'd0, bus.lo}, {32'd0, 32'h9ABCDEF0});
        run_op("divu_by_zero", MDU_DIVU, 32'd55, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10);

        // Requests and mthi during busy must be ignored
        bus.start = 1'b1;
        bus.op    = MDU_MULT;
        bus.a     = 32'd3;
        bus.b     = 32'd5;
        step();
        count_busy(1'b1, n);
        bus.start = 1'b0;
        bus.op    = MDU_NONE;
        chk("overlap_busy_cycles", 64'(n), 64'd5);
        chk("overlap_done", {63'd0, bus.done}, 64'd1);
        chk("overlap_hi", {32'd0, bus.hi}, 64'd0);
        chk("overlap_lo", {32'd0, bus.lo}, 64'd15);
        step();
        chk("overlap_no_restart", {63'd0, bus.busy}, 64'd0);

        // Reset mid-divide clears everything at once and suppresses done
        bus.start = 1'b1;
        bus.op    = MDU_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        step();
        bus.start = 1'b0;
        bus.op    = MDU_NONE;
        step();
        step();
        chk("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_busy", {63'd0, bus.busy}, 64'd0);
        chk("async_reset_hi", {32'd0, bus.hi}, 64'd0);
        chk("async_reset_lo", {32'd0, bus.lo}, 64'd0);
        #2;
        reset = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        chk("no_done_after_reset", {63'd0, saw_done}, 64'd0);
        run_op("mult_after_reset", MDU_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
